imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/loader_byte_packer.sv | 46 ++++
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared processor definitions used by the instruction-memory loader:
// loader FSM state encodings, checksum width and checksum fold helper.
package imem_loader_pkg;

  localparam int CHK_W = 8;

  typedef enum logic [2:0] {
    LD_IDLE    = 3'd0,
    LD_COLLECT = 3'd1,
    LD_WRITE   = 3'd2,
    LD_CHECK   = 3'd3,
    LD_DONE    = 3'd4
  } ld_state_e;

  // Running XOR checksum: fold one more byte into the accumulator.
  function automatic logic [CHK_W-1:0] chk_fold(input logic [CHK_W-1:0] acc,
                                                input logic [CHK_W-1:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Big-endian 4-byte word assembler with byte counter and XOR checksum
// accumulator for the instruction-memory loader.
module loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             clear,
  input  logic             take,
  input  logic [7:0]       byte_in,
  output logic [31:0]      word_nxt,
  output logic             last_byte,
  output logic [CHK_W-1:0] chk_acc
);

  logic [23:0]      shift_r;
  logic [1:0]       byte_idx_r;
  logic [CHK_W-1:0] acc_r;

  // Earlier bytes sit in the upper lanes, so the 4th byte completes the word.
  assign word_nxt  = {shift_r, byte_in};
  assign last_byte = (byte_idx_r == 2'd3);
  assign chk_acc   = acc_r;

  // Shift register, byte index and checksum update on each accepted byte.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      shift_r    <= 24'h00_0000;
      byte_idx_r <= 2'd0;
      acc_r      <= {CHK_W{1'b0}};
    end else if (clear) begin
      shift_r    <= 24'h00_0000;
      byte_idx_r <= 2'd0;
      acc_r      <= {CHK_W{1'b0}};
    end else if (take) begin
      shift_r    <= word_nxt[23:0];
      byte_idx_r <= byte_idx_r + 2'd1;
      acc_r      <= chk_fold(acc_r, byte_in);
    end else begin
      shift_r    <= shift_r;
      byte_idx_r <= byte_idx_r;
      acc_r      <= acc_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian words, writes
// them to consecutive IMEM addresses and verifies a trailing XOR checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          CNT_W     = 8
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             LD_start,
  input  logic [CNT_W-1:0] LD_word_count,
  input  logic             LD_byte_valid,
  input  logic [7:0]       LD_byte,
  output logic             LD_byte_ready,
  output logic             IMEM_wr_en,
  output logic [31:0]      IMEM_wr_addr,
  output logic [31:0]      IMEM_wr_data,
  output logic             LD_busy,
  output logic             LD_done,
  output logic             LD_error
);

  ld_state_e        state_r;
  ld_state_e        state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] word_idx_r;
  logic [CNT_W-1:0] word_idx_inc_s;
  logic             start_ok_s;
  logic             xfer_s;
  logic             take_s;
  logic             last_byte_s;
  logic             last_word_s;
  logic [31:0]      word_nxt_s;
  logic [CHK_W-1:0] chk_acc_s;
  logic             ready_nxt_s;
  logic             busy_nxt_s;
  logic             wr_en_nxt_s;
  logic             done_nxt_s;

  assign start_ok_s     = (state_r == LD_IDLE) && LD_start;
  assign xfer_s         = LD_byte_valid && LD_byte_ready;
  assign take_s         = xfer_s && (state_r == LD_COLLECT);
  assign word_idx_inc_s = word_idx_r + CNT_W'(1'b1);
  assign last_word_s    = (word_idx_inc_s == count_r);

  loader_byte_packer u_packer (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .clear     (start_ok_s),
    .take      (take_s),
    .byte_in   (LD_byte),
    .word_nxt  (word_nxt_s),
    .last_byte (last_byte_s),
    .chk_acc   (chk_acc_s)
  );

  // FSM state register.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_r <= LD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LD_IDLE: begin
        if (!LD_start) begin
          state_nxt_s = LD_IDLE;
        end else if (LD_word_count == {CNT_W{1'b0}}) begin
          state_nxt_s = LD_CHECK;
        end else begin
          state_nxt_s = LD_COLLECT;
        end
      end
      LD_COLLECT: begin
        if (take_s && last_byte_s) begin
          state_nxt_s = LD_WRITE;
        end else begin
          state_nxt_s = LD_COLLECT;
        end
      end
      LD_WRITE: begin
        if (last_word_s) begin
          state_nxt_s = LD_CHECK;
        end else begin
          state_nxt_s = LD_COLLECT;
        end
      end
      LD_CHECK: begin
        if (xfer_s) begin
          state_nxt_s = LD_DONE;
        end else begin
          state_nxt_s = LD_CHECK;
        end
      end
      LD_DONE: state_nxt_s = LD_IDLE;
      default: state_nxt_s = LD_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every strobe is a flop output.
  always_comb begin
    ready_nxt_s = 1'b0;
    busy_nxt_s  = 1'b0;
    wr_en_nxt_s = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_nxt_s)
      LD_IDLE: begin
        busy_nxt_s = 1'b0;
      end
      LD_COLLECT: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
      end
      LD_WRITE: begin
        busy_nxt_s  = 1'b1;
        wr_en_nxt_s = 1'b1;
      end
      LD_CHECK: begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b1;
      end
      LD_DONE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      LD_byte_ready <= 1'b0;
      LD_busy       <= 1'b0;
      IMEM_wr_en    <= 1'b0;
      LD_done       <= 1'b0;
    end else begin
      LD_byte_ready <= ready_nxt_s;
      LD_busy       <= busy_nxt_s;
      IMEM_wr_en    <= wr_en_nxt_s;
      LD_done       <= done_nxt_s;
    end
  end

  // Write address/data captured as the 4th byte lands, then held.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      IMEM_wr_addr <= 32'h0000_0000;
      IMEM_wr_data <= 32'h0000_0000;
    end else if (take_s && last_byte_s) begin
      IMEM_wr_addr <= ADDR_BASE + 32'({word_idx_r, 2'b00});
      IMEM_wr_data <= word_nxt_s;
    end else begin
      IMEM_wr_addr <= IMEM_wr_addr;
      IMEM_wr_data <= IMEM_wr_data;
    end
  end

  // Latched word count and word index.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      count_r    <= {CNT_W{1'b0}};
      word_idx_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      count_r    <= LD_word_count;
      word_idx_r <= {CNT_W{1'b0}};
    end else if (state_r == LD_WRITE) begin
      count_r    <= count_r;
      word_idx_r <= word_idx_inc_s;
    end else begin
      count_r    <= count_r;
      word_idx_r <= word_idx_r;
    end
  end

  // Sticky checksum error, cleared only by an accepted start.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      LD_error <= 1'b0;
    end else if (start_ok_s) begin
      LD_error <= 1'b0;
    end else if ((state_r == LD_CHECK) && xfer_s && (LD_byte != chk_acc_s)) begin
      LD_error <= 1'b1;
    end else begin
      LD_error <= LD_error;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed loads plus randomized loads
// checked against a transaction-level model of words, addresses and checksum.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        LD_start;
  logic [7:0]  LD_word_count;
  logic        LD_byte_valid;
  logic [7:0]  LD_byte;
  logic        LD_byte_ready;
  logic        IMEM_wr_en;
  logic [31:0] IMEM_wr_addr;
  logic [31:0] IMEM_wr_data;
  logic        LD_busy;
  logic        LD_done;
  logic        LD_error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          mon_en = 1'b0;
  wr_t         exp_q[$];
  logic [7:0]  ld_bytes[$];
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_data = 32'h0;

  imem_loader #(.ADDR_BASE(BASE), .CNT_W(8)) dut (
    .SYS_clk       (SYS_clk),
    .SYS_reset     (SYS_reset),
    .LD_start      (LD_start),
    .LD_word_count (LD_word_count),
    .LD_byte_valid (LD_byte_valid),
    .LD_byte       (LD_byte),
    .LD_byte_ready (LD_byte_ready),
    .IMEM_wr_en    (IMEM_wr_en),
    .IMEM_wr_addr  (IMEM_wr_addr),
    .IMEM_wr_data  (IMEM_wr_data),
    .LD_busy       (LD_busy),
    .LD_done       (LD_done),
    .LD_error      (LD_error)
  );

  always #5 SYS_clk = ~SYS_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xor_bytes();
    logic [7:0] x = 8'h00;
    foreach (ld_bytes[i]) x ^= ld_bytes[i];
    return x;
  endfunction

  initial forever begin
    @(posedge SYS_clk);
    cyc++;
  end

  // Output monitor: writes against the expectation queue, hold behaviour, reset.
  initial begin
    logic rst_edge;
    wr_t  w;
    forever begin
      @(posedge SYS_clk);
      rst_edge = SYS_reset;
      @(negedge SYS_clk);
      if (mon_en) begin
        if (rst_edge) begin
          last_addr = 32'h0;
          last_data = 32'h0;
          check("rst_busy", 32'(LD_busy), 32'd0);
          check("rst_ready", 32'(LD_byte_ready), 32'd0);
          check("rst_done", 32'(LD_done), 32'd0);
          check("rst_error", 32'(LD_error), 32'd0);
        end
        if (IMEM_wr_en) begin
          if (exp_q.size() == 0) begin
            check("wr_unexpected", 32'(IMEM_wr_en), 32'd0);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", IMEM_wr_addr, w.addr);
            check("wr_data", IMEM_wr_data, w.data);
            last_addr = w.addr;
            last_data = w.data;
          end
        end else begin
          check("hold_addr", IMEM_wr_addr, last_addr);
          check("hold_data", IMEM_wr_data, last_data);
        end
        if (LD_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int n = 0;
    LD_byte_valid = 1'b1;
    LD_byte = b;
    do begin
      rdy = LD_byte_ready;
      @(posedge SYS_clk);
      #1;
      n++;
    end while (!rdy && n < 64);
    check("byte_accept", 32'(rdy), 32'd1);
  endtask

  // One full load of ld_bytes (4*n bytes) followed by checksum chk.
  task automatic run_load(input int n, input logic [7:0] chk, input bit gaps,
                          input int gap_at, input bit idle_junk, input bit chk_lat);
    logic [7:0] x;
    int         start_cyc;
    int         d0;
    int         t;
    wr_t        w;
    x = xor_bytes();
    if (idle_junk) begin
      LD_byte_valid = 1'b1;
      LD_byte = 8'($urandom_range(255, 0));
      @(posedge SYS_clk);
      #1;
    end
    LD_word_count = 8'(n);
    LD_start = 1'b1;
    @(posedge SYS_clk);
    #1;
    LD_start = 1'b0;
    start_cyc = cyc;
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ((4 * i + k) == gap_at) begin
          LD_byte_valid = 1'b0;
          LD_start = 1'b1;
          LD_word_count = 8'd5;
          repeat (3) begin
            @(posedge SYS_clk);
            #1;
            LD_start = 1'b0;
          end
        end else if (gaps && $urandom_range(3, 0) == 0) begin
          LD_byte_valid = 1'b0;
          LD_start = 1'($urandom_range(1, 0));
          LD_word_count = 8'($urandom_range(7, 0));
          repeat ($urandom_range(3, 1)) begin
            @(posedge SYS_clk);
            #1;
            LD_start = 1'b0;
          end
        end
        send_byte(ld_bytes[4 * i + k]);
      end
      w.addr = BASE + 32'(4 * i);
      w.data = {ld_bytes[4 * i], ld_bytes[4 * i + 1], ld_bytes[4 * i + 2], ld_bytes[4 * i + 3]};
      exp_q.push_back(w);
    end
    send_byte(chk);
    LD_byte_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 64) begin
      @(posedge SYS_clk);
      #1;
      t++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    if (chk_lat) check("done_latency", 32'(done_cyc - start_cyc), 32'(5 * n + 1));
    check("error_after_done", 32'(LD_error), 32'(chk != x));
    check("busy_after_done", 32'(LD_busy), 32'd0);
    @(posedge SYS_clk);
    #1;
    check("error_in_idle", 32'(LD_error), 32'(chk != x));
    check("done_single", 32'(done_cnt - d0), 32'd1);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int         n;
    int         d0;
    logic [7:0] chk;
    wr_t        w;
    SYS_reset = 1'b1;
    LD_start = 1'b0;
    LD_word_count = 8'd0;
    LD_byte_valid = 1'b0;
    LD_byte = 8'h00;
    repeat (3) @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;
    check("reset_busy", 32'(LD_busy), 32'd0);
    check("reset_ready", 32'(LD_byte_ready), 32'd0);
    check("reset_wr_en", 32'(IMEM_wr_en), 32'd0);
    check("reset_done", 32'(LD_done), 32'd0);
    check("reset_error", 32'(LD_error), 32'd0);
    check("reset_addr", IMEM_wr_addr, 32'h0);
    check("reset_data", IMEM_wr_data, 32'h0);
    mon_en = 1'b1;

    ld_bytes = '{8'h20, 8'h08, 8'h00, 8'h05};
    run_load(1, 8'h2D, 1'b0, -1, 1'b0, 1'b1);

    ld_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(2, 8'h77, 1'b0, -1, 1'b0, 1'b1);

    ld_bytes = {};
    run_load(0, 8'h00, 1'b0, -1, 1'b1, 1'b1);

    ld_bytes = {};
    for (int i = 0; i < 12; i++) ld_bytes.push_back(8'($urandom_range(255, 0)));
    run_load(3, xor_bytes(), 1'b0, 6, 1'b0, 1'b0);

    // Reset in the middle of word 1, with a start request in the same cycle.
    ld_bytes = {};
    for (int i = 0; i < 8; i++) ld_bytes.push_back(8'(8'h40 + 8'(i)));
    LD_word_count = 8'd2;
    LD_start = 1'b1;
    @(posedge SYS_clk);
    #1;
    LD_start = 1'b0;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) send_byte(ld_bytes[k]);
    w.addr = BASE;
    w.data = {ld_bytes[0], ld_bytes[1], ld_bytes[2], ld_bytes[3]};
    exp_q.push_back(w);
    send_byte(ld_bytes[4]);
    send_byte(ld_bytes[5]);
    SYS_reset = 1'b1;
    LD_start = 1'b1;
    @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;
    LD_start = 1'b0;
    LD_byte_valid = 1'b0;
    check("abort_busy", 32'(LD_busy), 32'd0);
    check("abort_ready", 32'(LD_byte_ready), 32'd0);
    repeat (8) @(posedge SYS_clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_writes", 32'(exp_q.size()), 32'd0);
    check("abort_idle", 32'(LD_busy), 32'd0);
    ld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(1, xor_bytes(), 1'b0, -1, 1'b0, 1'b1);

    for (int r = 0; r < 24; r++) begin
      n = $urandom_range(5, 0);
      ld_bytes = {};
      for (int i = 0; i < 4 * n; i++) ld_bytes.push_back(8'($urandom_range(255, 0)));
      chk = xor_bytes();
      if ($urandom_range(3, 0) == 0) chk = chk ^ 8'($urandom_range(255, 1));
      if (r % 2 == 0) begin
        run_load(n, chk, 1'b0, -1, 1'($urandom_range(1, 0)), 1'b1);
      end else begin
        run_load(n, chk, 1'b1, -1, 1'($urandom_range(1, 0)), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
